// File: rtl/mac_pkg.sv
// Shared constants, sequencer state encoding and lane packing helpers for the
// 8-lane signed int8 dot-product datapath.
package mac_pkg;
  localparam int LANES       = 8;
  localparam int IN_W        = 8;
  localparam int RES_W       = 19;
  localparam int MAC_LAT_DEF = 2;
  localparam int VEC_W       = LANES * IN_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  function automatic logic signed [IN_W-1:0] lane_get(input logic [VEC_W-1:0] vec,
                                                      input int unsigned k);
    return vec[k*IN_W +: IN_W];
  endfunction

  function automatic logic [VEC_W-1:0] lane_put(input logic [VEC_W-1:0] vec,
                                                input int unsigned k,
                                                input logic [IN_W-1:0] val);
    logic [VEC_W-1:0] r_vec;
    r_vec = vec;
    r_vec[k*IN_W +: IN_W] = val;
    return r_vec;
  endfunction
endpackage

// File: rtl/mac_sat_acc.sv
// Wide signed accumulator for MAC partial sums: clear, add-enable, sign
// extension of the 19-bit input, clamp to the ACC_W range and sticky overflow.
module mac_sat_acc
  import mac_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [RES_W-1:0] i_add,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_ovf
);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;

  // One guard bit: the two top bits disagree exactly when the true sum left range.
  assign w_sum = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-RES_W){i_add[RES_W-1]}}, i_add};
  assign w_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      if (w_ovf) begin
        r_acc <= w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/mac_dot_seq.sv
// Streams a command's worth of 8-lane operand beats into a fixed-latency MAC
// and accumulates the returned sums into one saturating dot-product result.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int ACC_W   = 32,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_dat_valid,
  output logic             o_dat_ready,
  input  logic [VEC_W-1:0] i_dat_a,
  input  logic [VEC_W-1:0] i_dat_b,
  output logic [VEC_W-1:0] o_mac_a,
  output logic [VEC_W-1:0] o_mac_b,
  input  logic [RES_W-1:0] i_mac_res,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [ACC_W-1:0] o_res,
  output logic             o_res_ovf
);
  state_e             r_state;
  state_e             w_state_next;
  logic [LEN_W-1:0]   r_rem;
  logic [MAC_LAT-1:0] r_vld_sr;
  logic               w_cmd_fire;
  logic               w_fire;
  logic [ACC_W-1:0]   w_acc;
  logic               w_ovf;

  assign w_cmd_fire = (r_state == IDLE) && i_cmd_valid;
  assign w_fire     = (r_state == RUN) && i_dat_valid;

  always_comb begin
    w_state_next = r_state;
    o_cmd_ready  = 1'b0;
    o_dat_ready  = 1'b0;
    o_res_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) w_state_next = (i_cmd_len == '0) ? DONE : RUN;
      end
      RUN: begin
        o_dat_ready = 1'b1;
        if (w_fire && r_rem == LEN_W'(1)) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (r_vld_sr == '0) w_state_next = DONE;
      end
      DONE: begin
        o_res_valid = 1'b1;
        if (i_res_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // vld_sr tracks which MAC pipeline slots hold a real beat, so bubbles never reach the sum.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_vld_sr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_vld_sr <= MAC_LAT'({r_vld_sr, w_fire});
      if (w_cmd_fire)  r_rem <= i_cmd_len;
      else if (w_fire) r_rem <= r_rem - LEN_W'(1);
    end
  end

  mac_sat_acc #(
    .ACC_W(ACC_W)
  ) u_acc (
    .i_clk (i_clk),
    .i_nrst(i_nrst),
    .i_clr (w_cmd_fire),
    .i_en  (r_vld_sr[MAC_LAT-1]),
    .i_add (i_mac_res),
    .o_acc (w_acc),
    .o_ovf (w_ovf)
  );

  assign o_mac_a   = w_fire ? i_dat_a : '0;
  assign o_mac_b   = w_fire ? i_dat_b : '0;
  assign o_res     = (r_state == DONE) ? w_acc : '0;
  assign o_res_ovf = (r_state == DONE) && w_ovf;
endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: a 32-bit and a 20-bit accumulator instance share all
// stimulus, each fed by its own 2-cycle MAC model; results checked against an arithmetic reference.
module tb_mac_dot_seq;
  logic        i_clk = 1'b0;
  logic        i_nrst, i_cmd_valid, i_dat_valid, i_res_ready;
  logic [15:0] i_cmd_len;
  logic [63:0] i_dat_a, i_dat_b;

  logic        cmd_ready, dat_ready, res_valid, res_ovf;
  logic [63:0] mac_a, mac_b;
  logic [31:0] res;
  logic        cmd_ready20, dat_ready20, res_valid20, res_ovf20;
  logic [63:0] mac_a20, mac_b20;
  logic [19:0] res20;
  logic [18:0] p1, p2, q1, q2;

  int checks = 0;
  int errors = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  bit          q_v[$];

  always #5 i_clk = ~i_clk;

  mac_dot_seq #(.LEN_W(16), .ACC_W(32), .MAC_LAT(2)) u_dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_len(i_cmd_len), .i_dat_valid(i_dat_valid), .o_dat_ready(dat_ready),
    .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .o_mac_a(mac_a), .o_mac_b(mac_b),
    .i_mac_res(p2), .o_res_valid(res_valid), .i_res_ready(i_res_ready),
    .o_res(res), .o_res_ovf(res_ovf));

  mac_dot_seq #(.LEN_W(16), .ACC_W(20), .MAC_LAT(2)) u_dut20 (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(cmd_ready20),
    .i_cmd_len(i_cmd_len), .i_dat_valid(i_dat_valid), .o_dat_ready(dat_ready20),
    .i_dat_a(i_dat_a), .i_dat_b(i_dat_b), .o_mac_a(mac_a20), .o_mac_b(mac_b20),
    .i_mac_res(q2), .o_res_valid(res_valid20), .i_res_ready(i_res_ready),
    .o_res(res20), .o_res_ovf(res_ovf20));

  function automatic int lane_dot(input logic [63:0] a, input logic [63:0] b);
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
    return s;
  endfunction

  // Behavioural MAC: dot product registered twice, shares the sequencer reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      p1 <= '0; p2 <= '0; q1 <= '0; q2 <= '0;
    end else begin
      p1 <= 19'(lane_dot(mac_a, mac_b));
      p2 <= p1;
      q1 <= 19'(lane_dot(mac_a20, mac_b20));
      q2 <= q1;
    end
  end

  function automatic void sat_add(inout longint acc, inout bit ovf, input longint d, input int w);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -(longint'(1) <<< (w - 1));
    acc = acc + d;
    if (acc > mx) begin acc = mx; ovf = 1'b1; end
    else if (acc < mn) begin acc = mn; ovf = 1'b1; end
  endfunction

  function automatic logic [63:0] ramp();
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(k + 1);
    return r;
  endfunction

  task automatic clear_q();
    q_a.delete(); q_b.delete(); q_v.delete();
  endtask

  // One command end to end: beats from q_a/q_b, valid pattern from q_v (then all 1).
  task automatic run_cmd(input int len, input int hold, input string name);
    longint e32 = 0, e20 = 0;
    bit     o32 = 0, o20 = 0;
    int     idx = 0, vi = 0, c = 1, last_fire = 0, bad_mac = 0, bad_rdy = 0, bad_hold = 0, exp_lat;
    bit     v, fire;
    logic [63:0] ea, eb;
    for (int i = 0; i < len; i++) begin
      sat_add(e32, o32, longint'(lane_dot(q_a[i], q_b[i])), 32);
      sat_add(e20, o20, longint'(lane_dot(q_a[i], q_b[i])), 20);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready_idle got %b want 1", name, cmd_ready);
    end
    i_cmd_valid = 1'b1; i_cmd_len = len[15:0]; i_res_ready = 1'b0;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0; i_cmd_len = 16'($urandom);
    while (res_valid !== 1'b1 && c < 300) begin
      if (idx < len) begin
        v = (vi < q_v.size()) ? q_v[vi] : 1'b1;
        vi++;
      end else v = 1'b0;
      i_dat_valid = v;
      i_dat_a = v ? q_a[idx] : {$urandom, $urandom};
      i_dat_b = v ? q_b[idx] : {$urandom, $urandom};
      #1;
      fire = v && (dat_ready === 1'b1);
      if (dat_ready !== (idx < len) || dat_ready20 !== (idx < len)) bad_rdy++;
      ea = fire ? q_a[idx] : 64'd0;
      eb = fire ? q_b[idx] : 64'd0;
      if (mac_a !== ea || mac_b !== eb || mac_a20 !== ea || mac_b20 !== eb) bad_mac++;
      if (fire) begin idx++; last_fire = c; end
      @(posedge i_clk); #1;
      i_dat_valid = 1'b0;
      c++;
    end
    exp_lat = (len == 0) ? 1 : last_fire + 4;
    checks++;
    if (res_valid !== 1'b1 || c != exp_lat) begin
      errors++; $display("FAIL %s valid_cycle got %0d (valid %b) want %0d", name, c, res_valid, exp_lat);
    end
    checks++;
    if (idx != len) begin errors++; $display("FAIL %s beats_taken got %0d want %0d", name, idx, len); end
    checks++;
    if (bad_mac != 0) begin errors++; $display("FAIL %s mac_operands bad_cycles %0d want 0", name, bad_mac); end
    checks++;
    if (bad_rdy != 0) begin errors++; $display("FAIL %s dat_ready bad_cycles %0d want 0", name, bad_rdy); end
    checks++;
    if (longint'($signed(res)) != e32 || res_ovf !== o32) begin
      errors++; $display("FAIL %s res32 got %0d ovf %b want %0d ovf %b", name, $signed(res), res_ovf, e32, o32);
    end
    checks++;
    if (res_valid20 !== 1'b1 || longint'($signed(res20)) != e20 || res_ovf20 !== o20) begin
      errors++; $display("FAIL %s res20 got %0d ovf %b want %0d ovf %b", name, $signed(res20), res_ovf20, e20, o20);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clk); #1;
      if (res_valid !== 1'b1 || longint'($signed(res)) != e32 || res_ovf !== o32 ||
          cmd_ready !== 1'b0 || dat_ready !== 1'b0 || mac_a !== 64'd0 || mac_b !== 64'd0 ||
          longint'($signed(res20)) != e20 || res_ovf20 !== o20) bad_hold++;
    end
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL %s held_result bad_cycles %0d want 0", name, bad_hold); end
    i_res_ready = 1'b1;
    @(posedge i_clk); #1;
    i_res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_valid20 !== 1'b0 || cmd_ready20 !== 1'b1) begin
      errors++; $display("FAIL %s after_accept valid %b cmd_ready %b want 0 1", name, res_valid, cmd_ready);
    end
    $display("txn %s len=%0d res=%0d ovf=%b res20=%0d ovf20=%b latency=%0d", name, len,
             $signed(res), o32, e20, o20, c);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (cmd_ready !== 1'b1 || dat_ready !== 1'b0 || res_valid !== 1'b0 || res !== 32'd0 ||
        res_ovf !== 1'b0 || mac_a !== 64'd0 || mac_b !== 64'd0) begin
      errors++;
      $display("FAIL %s outputs got cmd_rdy %b dat_rdy %b vld %b res %0d ovf %b mac_a %h want 1 0 0 0 0 0",
               name, cmd_ready, dat_ready, res_valid, res, res_ovf, mac_a);
    end
    checks++;
    if (cmd_ready20 !== 1'b1 || dat_ready20 !== 1'b0 || res_valid20 !== 1'b0 || res20 !== 20'd0 ||
        res_ovf20 !== 1'b0) begin
      errors++; $display("FAIL %s outputs20 got cmd_rdy %b vld %b res %0d want 1 0 0", name, cmd_ready20, res_valid20, res20);
    end
  endtask

  task automatic load_single();
    clear_q(); q_a.push_back({8{8'd1}}); q_b.push_back(ramp());
  endtask

  task automatic test_reset();
    i_nrst = 1'b0; i_cmd_valid = 1'b0; i_cmd_len = '0; i_dat_valid = 1'b0;
    i_dat_a = '0; i_dat_b = '0; i_res_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_idle_outputs("reset");
    i_nrst = 1'b1;
  endtask

  task automatic test_single();
    load_single();
    run_cmd(1, 0, "single");
  endtask

  task automatic test_bubbles();
    clear_q();
    for (int i = 0; i < 4; i++) begin q_a.push_back(ramp()); q_b.push_back({8{8'd2}}); end
    q_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_cmd(4, 0, "bubbles");
  endtask

  task automatic test_extremes();
    clear_q();
    for (int i = 0; i < 3; i++) begin q_a.push_back({8{8'h80}}); q_b.push_back({8{8'h80}}); end
    run_cmd(3, 1, "neg_x_neg");
    clear_q();
    for (int i = 0; i < 2; i++) begin q_a.push_back({8{8'h80}}); q_b.push_back({8{8'h7f}}); end
    run_cmd(2, 0, "neg_x_pos");
  endtask

  task automatic test_saturation();
    clear_q();
    for (int i = 0; i < 4; i++) begin q_a.push_back({8{8'h80}}); q_b.push_back({8{8'h80}}); end
    run_cmd(4, 2, "saturate");
    load_single();
    run_cmd(1, 0, "ovf_cleared");
  endtask

  task automatic test_zero_len_hold();
    clear_q();
    run_cmd(0, 10, "zero_len_hold");
  endtask

  task automatic test_reset_mid();
    clear_q();
    for (int i = 0; i < 5; i++) begin q_a.push_back({$urandom, $urandom}); q_b.push_back({$urandom, $urandom}); end
    i_cmd_valid = 1'b1; i_cmd_len = 16'd5;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_dat_valid = 1'b1; i_dat_a = q_a[i]; i_dat_b = q_b[i];
      @(posedge i_clk); #1;
    end
    i_dat_valid = 1'b0; i_nrst = 1'b0;
    @(posedge i_clk); #1;
    check_idle_outputs("reset_mid");
    i_nrst = 1'b1;
    load_single();
    run_cmd(1, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int len = $urandom_range(0, 10);
      bit big = ($urandom_range(0, 3) == 0);
      clear_q();
      for (int i = 0; i < len; i++) begin
        q_a.push_back(big ? {8{8'h80}} : {$urandom, $urandom});
        q_b.push_back(big ? (($urandom_range(0, 4) == 0) ? {8{8'h7f}} : {8{8'h80}}) : {$urandom, $urandom});
      end
      for (int i = 0; i < 2 * len; i++) q_v.push_back(1'($urandom_range(0, 1)));
      run_cmd(len, $urandom_range(0, 3), $sformatf("random%0d", t));
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      int len = $urandom_range(1, 6);
      clear_q();
      for (int i = 0; i < len; i++) begin q_a.push_back({$urandom, $urandom}); q_b.push_back({$urandom, $urandom}); end
      run_cmd(len, 0, $sformatf("b2b%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bubbles();
    test_extremes();
    test_saturation();
    test_zero_len_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
